// File: rtl/instr_trace_if.sv
// CPU-side capture signals and console-side control/status for the instruction trace buffer.
interface instr_trace_if #(
  parameter int unsigned DEPTH_LOG2 = 9
);
  logic [18:35]        cpuPC;
  logic [0:35]         cpuHR;
  logic                regsLOAD;
  logic                cpuHALT;
  logic                trcEN;
  logic                trcWRAP;
  logic                trigEN;
  logic [18:35]        trigPC;
  logic                trcCLR;
  logic                trcPOP;
  logic [18:35]        trcPC;
  logic [0:35]         trcIR;
  logic                trcEMPTY;
  logic                trcFULL;
  logic [DEPTH_LOG2:0] trcCOUNT;
  logic                trcOVFL;
  logic [1:0]          trcSTATE;

  modport master (
    output cpuPC, cpuHR, regsLOAD, cpuHALT, trcEN, trcWRAP, trigEN, trigPC, trcCLR, trcPOP,
    input  trcPC, trcIR, trcEMPTY, trcFULL, trcCOUNT, trcOVFL, trcSTATE
  );

  modport slave (
    input  cpuPC, cpuHR, regsLOAD, cpuHALT, trcEN, trcWRAP, trigEN, trigPC, trcCLR, trcPOP,
    output trcPC, trcIR, trcEMPTY, trcFULL, trcCOUNT, trcOVFL, trcSTATE
  );
endinterface

// File: rtl/instr_trace.sv
// Instruction trace buffer: captures {PC, HR} per instruction-register load into a circular
// FIFO, gated by console enable, optional PC trigger and CPU halt; drained by the console.
module instr_trace #(
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic           clk,
  input  logic           rst,
  instr_trace_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ARMED   = 2'b01,
    S_CAPTURE = 2'b10,
    S_DONE    = 2'b11
  } state_e;

  typedef struct packed {
    logic [18:35] pc;
    logic [0:35]  hr;
  } rec_t;

  state_e             state_q, state_d;
  logic               load_q;
  logic               wr_q, wr_d;
  rec_t               rec_q;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               empty_q, full_q, ovfl_q, ovfl_d;
  rec_t               rd_q, out_q;
  rec_t               mem [DEPTH];

  logic evt_c, trig_hit_c, wr_fire_c, overwrite_c, pop_fire_c;

  assign evt_c       = bus.regsLOAD & ~load_q;
  assign trig_hit_c  = (bus.cpuPC == bus.trigPC);
  // A full buffer only accepts the pending record when overwriting is allowed.
  assign wr_fire_c   = wr_q & ~bus.trcCLR & (~full_q | bus.trcWRAP);
  assign overwrite_c = wr_fire_c & full_q;
  assign pop_fire_c  = bus.trcPOP & ~bus.trcCLR & ~empty_q & ~overwrite_c;

  // Pointer, count and overflow next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovfl_d   = ovfl_q;
    if (bus.trcCLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovfl_d   = 1'b0;
    end else begin
      if (wr_fire_c)                  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire_c || overwrite_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (!overwrite_c)               cnt_d = cnt_q + CNT_W'(wr_fire_c) - CNT_W'(pop_fire_c);
      if (overwrite_c)                ovfl_d = 1'b1;
    end
  end

  // Capture FSM; wr_d marks the edge-detected record as accepted for the next-cycle write.
  always_comb begin
    state_d = state_q;
    wr_d    = 1'b0;
    if (bus.trcCLR || !bus.trcEN) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_ARMED;
        S_ARMED: begin
          if (!bus.trigEN) begin
            state_d = S_CAPTURE;
            wr_d    = evt_c;
          end else if (evt_c && trig_hit_c) begin
            state_d = S_CAPTURE;
            wr_d    = 1'b1;
          end
        end
        S_CAPTURE: begin
          wr_d = evt_c;
          if (bus.cpuHALT || (!bus.trcWRAP && cnt_d == CNT_W'(DEPTH))) state_d = S_DONE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      load_q   <= 1'b0;
      wr_q     <= 1'b0;
      rec_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovfl_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      load_q   <= bus.regsLOAD;
      wr_q     <= wr_d;
      rec_q    <= rec_t'({bus.cpuPC, bus.cpuHR});
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (cnt_d == CNT_W'(DEPTH));
      ovfl_q   <= ovfl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire_c) mem[wr_ptr_q] <= rec_q;
  end

  // Show-ahead head: synchronous RAM read followed by an output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      out_q <= '0;
    end else begin
      rd_q  <= mem[rd_ptr_q];
      out_q <= rd_q;
    end
  end

  assign bus.trcPC    = out_q.pc;
  assign bus.trcIR    = out_q.hr;
  assign bus.trcEMPTY = empty_q;
  assign bus.trcFULL  = full_q;
  assign bus.trcCOUNT = cnt_q;
  assign bus.trcOVFL  = ovfl_q;
  assign bus.trcSTATE = state_q;

endmodule

// File: tb/tb_instr_trace.sv
// Directed bench for instr_trace with an 8-record buffer: table-driven basic FIFO flow plus
// hand-written trigger, stop-full, wrap, halt/clear and async-reset sequences.
module tb_instr_trace;

  localparam int unsigned DL2 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_trace_if #(.DEPTH_LOG2(DL2)) bus ();

  instr_trace #(.DEPTH_LOG2(DL2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_pop;
    logic [17:0] pc;
    int          exp_cnt;
    logic        exp_empty;
    logic [17:0] exp_head;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [35:0] hr_of(input logic [17:0] pc);
    return 36'o254000000000 | 36'(pc);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [17:0] pc);
    bus.cpuPC    = pc;
    bus.cpuHR    = hr_of(pc);
    bus.regsLOAD = 1'b1;
    step();
    bus.regsLOAD = 1'b0;
    step();
  endtask

  task automatic pop();
    bus.trcPOP = 1'b1;
    step();
    bus.trcPOP = 1'b0;
    step();
  endtask

  task automatic clear();
    bus.trcCLR = 1'b1;
    step();
    bus.trcCLR = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc"},    64'(bus.trcPC),    64'(0));
    chk({tag, " ir"},    64'(bus.trcIR),    64'(0));
    chk({tag, " empty"}, 64'(bus.trcEMPTY), 64'(1));
    chk({tag, " full"},  64'(bus.trcFULL),  64'(0));
    chk({tag, " count"}, 64'(bus.trcCOUNT), 64'(0));
    chk({tag, " ovfl"},  64'(bus.trcOVFL),  64'(0));
    chk({tag, " state"}, 64'(bus.trcSTATE), 64'(0));
  endtask

  initial begin
    bus.cpuPC = '0; bus.cpuHR = '0; bus.regsLOAD = 1'b0; bus.cpuHALT = 1'b0;
    bus.trcEN = 1'b0; bus.trcWRAP = 1'b0; bus.trigEN = 1'b0; bus.trigPC = '0;
    bus.trcCLR = 1'b0; bus.trcPOP = 1'b0;

    vecs[0] = '{1'b0, 18'o100, 1, 1'b0, 18'o100, 2'b10};
    vecs[1] = '{1'b0, 18'o101, 2, 1'b0, 18'o100, 2'b10};
    vecs[2] = '{1'b0, 18'o102, 3, 1'b0, 18'o100, 2'b10};
    vecs[3] = '{1'b1, 18'o0,   2, 1'b0, 18'o101, 2'b10};
    vecs[4] = '{1'b1, 18'o0,   1, 1'b0, 18'o102, 2'b10};
    vecs[5] = '{1'b1, 18'o0,   0, 1'b1, 18'o0,   2'b10};
    vecs[6] = '{1'b1, 18'o0,   0, 1'b1, 18'o0,   2'b10};
    vecs[7] = '{1'b0, 18'o103, 1, 1'b0, 18'o103, 2'b10};

    step(); step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // Basic FIFO flow, trigger disabled.
    bus.trcEN = 1'b1;
    step();
    chk("armed state", 64'(bus.trcSTATE), 64'(1));
    step();
    chk("capture state", 64'(bus.trcSTATE), 64'(2));
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_pop) pop(); else pulse(vecs[i].pc);
      step(); step();
      chk($sformatf("v%0d count", i), 64'(bus.trcCOUNT), 64'(vecs[i].exp_cnt));
      chk($sformatf("v%0d empty", i), 64'(bus.trcEMPTY), 64'(vecs[i].exp_empty));
      chk($sformatf("v%0d state", i), 64'(bus.trcSTATE), 64'(vecs[i].exp_state));
      if (!vecs[i].exp_empty) begin
        chk($sformatf("v%0d head pc", i), 64'(bus.trcPC), 64'(vecs[i].exp_head));
        chk($sformatf("v%0d head ir", i), 64'(bus.trcIR), 64'(hr_of(vecs[i].exp_head)));
      end
    end

    // PC-match trigger.
    bus.trigEN = 1'b1;
    bus.trigPC = 18'o2000;
    clear();
    chk("clr count", 64'(bus.trcCOUNT), 64'(0));
    chk("clr state", 64'(bus.trcSTATE), 64'(0));
    step();
    pulse(18'o1776);
    pulse(18'o1777);
    chk("trig pre count", 64'(bus.trcCOUNT), 64'(0));
    chk("trig pre state", 64'(bus.trcSTATE), 64'(1));
    pulse(18'o2000);
    chk("trig hit state", 64'(bus.trcSTATE), 64'(2));
    pulse(18'o2001);
    step(); step();
    chk("trig count", 64'(bus.trcCOUNT), 64'(2));
    chk("trig head", 64'(bus.trcPC), 64'(18'o2000));
    bus.trigEN = 1'b0;

    // Stop when full.
    clear();
    step(); step();
    for (int i = 0; i < 10; i++) pulse(18'(18'o300 + i));
    step(); step();
    chk("stop count", 64'(bus.trcCOUNT), 64'(8));
    chk("stop full",  64'(bus.trcFULL),  64'(1));
    chk("stop ovfl",  64'(bus.trcOVFL),  64'(0));
    chk("stop state", 64'(bus.trcSTATE), 64'(3));
    chk("stop head",  64'(bus.trcPC),    64'(18'o300));

    // Overwrite oldest when full.
    bus.trcWRAP = 1'b1;
    clear();
    step(); step();
    for (int i = 0; i < 10; i++) pulse(18'(18'o300 + i));
    step(); step();
    chk("wrap count", 64'(bus.trcCOUNT), 64'(8));
    chk("wrap ovfl",  64'(bus.trcOVFL),  64'(1));
    chk("wrap state", 64'(bus.trcSTATE), 64'(2));
    chk("wrap head",  64'(bus.trcPC),    64'(18'o302));
    // Pop during the overwrite cycle is ignored.
    bus.cpuPC = 18'o312; bus.cpuHR = hr_of(18'o312); bus.regsLOAD = 1'b1;
    step();
    bus.regsLOAD = 1'b0; bus.trcPOP = 1'b1;
    step();
    bus.trcPOP = 1'b0;
    step(); step();
    chk("wrap pop count", 64'(bus.trcCOUNT), 64'(8));
    chk("wrap pop head",  64'(bus.trcPC),    64'(18'o303));
    bus.trcWRAP = 1'b0;

    // Halt coincident with a capture, then clear coincident with a capture.
    clear();
    step(); step();
    bus.cpuPC = 18'o500; bus.cpuHR = hr_of(18'o500);
    bus.regsLOAD = 1'b1; bus.cpuHALT = 1'b1;
    step();
    bus.regsLOAD = 1'b0; bus.cpuHALT = 1'b0;
    chk("halt state", 64'(bus.trcSTATE), 64'(3));
    step(); step(); step();
    chk("halt count", 64'(bus.trcCOUNT), 64'(1));
    chk("halt head",  64'(bus.trcPC),    64'(18'o500));
    pulse(18'o501);
    chk("done no capture", 64'(bus.trcCOUNT), 64'(1));
    bus.cpuPC = 18'o502; bus.cpuHR = hr_of(18'o502);
    bus.regsLOAD = 1'b1; bus.trcCLR = 1'b1;
    step();
    bus.regsLOAD = 1'b0; bus.trcCLR = 1'b0;
    chk("clr+pulse state", 64'(bus.trcSTATE), 64'(0));
    chk("clr+pulse count", 64'(bus.trcCOUNT), 64'(0));
    step(); step(); step();
    chk("clr dropped count", 64'(bus.trcCOUNT), 64'(0));
    chk("clr dropped empty", 64'(bus.trcEMPTY), 64'(1));

    // Async reset mid-capture.
    for (int i = 0; i < 5; i++) pulse(18'(18'o600 + i));
    step(); step();
    chk("pre-rst count", 64'(bus.trcCOUNT), 64'(5));
    chk("pre-rst head",  64'(bus.trcPC),    64'(18'o600));
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async rst");
    step();
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
